decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised ID stage for the MIPS pipeline. It decodes the instruction from IF/ID and extends the immediate to DWIDTH. It computes branch and JAL targets, interlocks on load-use hazards, and holds the result in an ID/EX register with valid/ready handshakes on both sides. Sits between the IF/ID register and the execute stage.

Parameters:
DWIDTH, 32, datapath and immediate-extension width
PCWIDTH, 32, program counter width
AWIDTH, 5, register address width
STALL_CNT_W, 16, width of the bubble counter

Ports:
ds_i_clk  in  1  clock
ds_i_rst  in  1  asynchronous active-low reset
ds_i_valid  in  1  IF/ID holds an instruction
ds_o_ready  out  1  stage accepts IF/ID this cycle
ds_i_instr  in  32  instruction word
ds_i_pc  in  PCWIDTH  PC of ds_i_instr
ds_i_flush  in  1  squash stage contents (branch/jump redirect)
ds_o_valid  out  1  ID/EX holds a valid decoded instruction
ds_i_ready  in  1  execute stage consumes ID/EX this cycle
ds_o_opcode  out  6  registered opcode
ds_o_funct  out  6  registered funct (0 for non-R-type)
ds_o_addr_rs, ds_o_addr_rt, ds_o_addr_rd  out  AWIDTH  register addresses
ds_o_imm  out  DWIDTH  extended immediate
ds_o_target  out  PCWIDTH  branch or JAL target
ds_o_link  out  PCWIDTH  pc+4 (JAL link value)
ds_o_alu_src, ds_o_reg_wr, ds_o_memwrite, ds_o_memtoreg, ds_o_branch, ds_o_jal, ds_o_jr  out  1 each  control
ds_o_illegal  out  1  one-cycle pulse: unknown opcode dropped
ds_o_stall_cnt  out  STALL_CNT_W  load-use bubbles inserted

Behaviour:
- Reset (ds_i_rst=0, asynchronous): all registered outputs go to 0, ds_o_valid=0, ds_o_stall_cnt=0.
- Decode is combinational from ds_i_instr. Opcode/funct values come from header.vh: RTYPE, LOAD, STORE, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, JAL, funct JR.
- Control signal values:
  - R-type: rd write, reg_wr=1.
  - JR: rs forced to 31, jr=1, reg_wr=0.
  - I-ALU ops: alu_src=1, reg_wr=1, rd=0.
  - LOAD: alu_src, reg_wr, memtoreg.
  - STORE: alu_src, memwrite.
  - BEQ/BNE: branch=1.
  - JAL: rd=31, reg_wr=1, jal=1.
- Immediate:
  - Sign-extend instr[15:0] to DWIDTH for ADDI, ADDIU, SLTI, SLTIU, LOAD, STORE, BEQ, BNE.
  - Zero-extend for ANDI, ORI.
  - 0 otherwise.
- Targets:
  - link = pc+4 (mod 2^PCWIDTH).
  - Branch target = pc+4 + (sext imm << 2), wraps.
  - JAL target = {link[PCWIDTH-1:28], instr[25:0], 2'b00}.
  - target = 0 for other instructions.
- Register load enable: ld = ~ds_o_valid | ds_i_ready.
- Load-use hazard (haz) is asserted when all of the following hold:
  - ds_o_valid=1 and ds_o_memtoreg=1;
  - ds_o_addr_rt != 0;
  - the incoming instruction reads ds_o_addr_rt as rs (any rs-using op, including JR's r31), or as rt (R-type, BEQ/BNE, STORE).
- ds_o_ready = ld & ~haz & ~ds_i_flush.
- Per-cycle update, highest priority first:
  1. ds_i_flush: ds_o_valid<=0, the input is not accepted, ds_o_illegal<=0.
  2. ld & haz: insert a bubble. ds_o_valid<=0, all control bits <=0, stall counter +1 (saturating at all-ones).
  3. ld & ds_i_valid & legal: capture the decode and set ds_o_valid<=1.
  4. ld & ds_i_valid & illegal: accept and drop it, ds_o_valid<=0, ds_o_illegal<=1 for one cycle.
  5. ld & ~ds_i_valid: ds_o_valid<=0.
  6. ~ld: hold every output (backpressure). Outputs must stay stable while ds_o_valid & ~ds_i_ready.
- ds_o_illegal is 0 in every cycle not covered by case 4.
- Latency: exactly 1 cycle from acceptance to ds_o_valid. A hazard costs exactly 1 bubble because the bubble clears ds_o_memtoreg.
- Mid-operation reset clears the stage immediately; no partial state survives.

Optional Feature:
DECODE_STAGE_STALL_CNT_EN
- Defined: the saturating bubble counter exists as specified.
- Undefined: the counter is not built and ds_o_stall_cnt is tied to 0. Hazard and bubble behaviour is unchanged.

Test Plan:
- Reset asserted mid-stream with ds_o_valid=1 -> outputs 0 immediately (asynchronous); after release, first ADDI $1,$0,-4 (0x2001FFFC) -> 1 cycle later ds_o_valid=1, imm=0xFFFFFFFC, alu_src=1, reg_wr=1.
- ANDI $2,$1,0x8000 -> imm=0x00008000 (zero-extend); BEQ at pc=0x100 with imm=0xFFFF -> target=0x100.
- LW $3,0($1) followed by ADD $4,$3,$5 -> one bubble cycle (ds_o_valid=0, ds_o_ready=0), then ADD issues; stall_cnt=1 (0 with the macro off). Same test with LW writing $0 -> no bubble.
- ds_i_ready=0 for 3 cycles with ds_o_valid=1 -> outputs constant, ds_o_ready=0; consumption then resumes in order.
- ds_i_flush in the same cycle as a valid hazard -> ds_o_valid=0, instruction not accepted, stall_cnt unchanged.
- Opcode 0x3F -> ds_o_illegal one-cycle pulse, ds_o_valid=0; JAL at pc=0x1000_0000 with target field 0x40 -> target=0x1000_0100, link=0x1000_0004, addr_rd=31.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID-side and ID/EX-side signal bundle for decode_stage.
// master: the decode stage (drives ds_o_*); slave: the surrounding pipeline (drives ds_i_*).
// Carries the IF/ID handshake (valid/ready/flush, instr, pc), the ID/EX handshake
// (valid/ready), the decoded fields, the control bits, the illegal pulse and the bubble count.
interface decode_stage_if #(
  parameter int DWIDTH      = 32,
  parameter int PCWIDTH     = 32,
  parameter int AWIDTH      = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   ds_i_valid, ds_o_ready, ds_i_flush, ds_o_valid, ds_i_ready;
  logic [31:0]            ds_i_instr;
  logic [PCWIDTH-1:0]     ds_i_pc, ds_o_target, ds_o_link;
  logic [5:0]             ds_o_opcode, ds_o_funct;
  logic [AWIDTH-1:0]      ds_o_addr_rs, ds_o_addr_rt, ds_o_addr_rd;
  logic [DWIDTH-1:0]      ds_o_imm;
  logic                   ds_o_alu_src, ds_o_reg_wr, ds_o_memwrite, ds_o_memtoreg;
  logic                   ds_o_branch, ds_o_jal, ds_o_jr, ds_o_illegal;
  logic [STALL_CNT_W-1:0] ds_o_stall_cnt;
  modport master (
    input  ds_i_valid, ds_i_instr, ds_i_pc, ds_i_flush, ds_i_ready,
    output ds_o_ready, ds_o_valid, ds_o_opcode, ds_o_funct, ds_o_addr_rs, ds_o_addr_rt,
           ds_o_addr_rd, ds_o_imm, ds_o_target, ds_o_link, ds_o_alu_src, ds_o_reg_wr,
           ds_o_memwrite, ds_o_memtoreg, ds_o_branch, ds_o_jal, ds_o_jr, ds_o_illegal,
           ds_o_stall_cnt
  );
  modport slave (
    output ds_i_valid, ds_i_instr, ds_i_pc, ds_i_flush, ds_i_ready,
    input  ds_o_ready, ds_o_valid, ds_o_opcode, ds_o_funct, ds_o_addr_rs, ds_o_addr_rt,
           ds_o_addr_rd, ds_o_imm, ds_o_target, ds_o_link, ds_o_alu_src, ds_o_reg_wr,
           ds_o_memwrite, ds_o_memtoreg, ds_o_branch, ds_o_jal, ds_o_jr, ds_o_illegal,
           ds_o_stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered MIPS ID stage with load-use interlock and ID/EX valid/ready handshake.
// Ports: ds_i_clk clock; ds_i_rst asynchronous active-low reset; bus (decode_stage_if.master)
// carrying IF/ID inputs, ID/EX handshake and all registered decode outputs.
// Optional: define DECODE_STAGE_STALL_CNT_EN to build the saturating bubble counter;
// otherwise ds_o_stall_cnt is tied to 0.
module decode_stage #(
  parameter int DWIDTH      = 32,
  parameter int PCWIDTH     = 32,
  parameter int AWIDTH      = 5,
  parameter int STALL_CNT_W = 16
) (
  input logic ds_i_clk,
  input logic ds_i_rst,
  decode_stage_if.master bus
);
  localparam logic [5:0] RTYPE = 6'h00, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05, ADDI = 6'h08,
                         ADDIU = 6'h09, SLTI = 6'h0a, SLTIU = 6'h0b, ANDI = 6'h0c, ORI = 6'h0d,
                         LOAD = 6'h23, STORE = 6'h2b, F_JR = 6'h08;
  typedef struct packed {
    logic [5:0]         opcode, funct;
    logic [AWIDTH-1:0]  rs, rt, rd;
    logic [DWIDTH-1:0]  imm;
    logic [PCWIDTH-1:0] target, link;
    logic               alu_src, reg_wr, memwrite, memtoreg, branch, jal, jr;
  } dec_t;
  dec_t dec, out_d, out_q;
  logic valid_d, valid_q, illegal_d, illegal_q, ld, haz;
  logic is_r, is_jr, is_ialu, is_ld, is_st, is_br, is_jal, legal, uses_rs, uses_rt;
  logic [5:0] op;
  logic [PCWIDTH-1:0] bofs;
  logic [DWIDTH-1:0] sext;
  assign op = bus.ds_i_instr[31:26];
  always_comb begin
    is_r    = op == RTYPE;
    is_jr   = is_r & (bus.ds_i_instr[5:0] == F_JR);
    is_ialu = op inside {ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI};
    is_ld   = op == LOAD;
    is_st   = op == STORE;
    is_br   = op inside {BEQ, BNE};
    is_jal  = op == JAL;
    legal   = is_r | is_ialu | is_ld | is_st | is_br | is_jal;
    uses_rs = is_r | is_ialu | is_ld | is_st | is_br;
    uses_rt = is_r | is_br | is_st;
    sext    = {{(DWIDTH-16){bus.ds_i_instr[15]}}, bus.ds_i_instr[15:0]};
    bofs    = {{(PCWIDTH-18){bus.ds_i_instr[15]}}, bus.ds_i_instr[15:0], 2'b00};
    dec          = '0;
    dec.opcode   = op;
    dec.funct    = is_r ? bus.ds_i_instr[5:0] : 6'd0;
    dec.rs       = is_jr ? AWIDTH'(31) : AWIDTH'(bus.ds_i_instr[25:21]);
    dec.rt       = AWIDTH'(bus.ds_i_instr[20:16]);
    dec.rd       = is_r ? AWIDTH'(bus.ds_i_instr[15:11]) : is_jal ? AWIDTH'(31) : '0;
    dec.imm      = (op inside {ANDI, ORI}) ? DWIDTH'(bus.ds_i_instr[15:0]) :
                   (is_ialu | is_ld | is_st | is_br) ? sext : '0;
    dec.link     = bus.ds_i_pc + PCWIDTH'(4);
    dec.target   = is_br ? dec.link + bofs :
                   is_jal ? {dec.link[PCWIDTH-1:28], bus.ds_i_instr[25:0], 2'b00} : '0;
    dec.alu_src  = is_ialu | is_ld | is_st;
    dec.reg_wr   = (is_r & ~is_jr) | is_ialu | is_ld | is_jal;
    dec.memwrite = is_st;
    dec.memtoreg = is_ld;
    dec.branch   = is_br;
    dec.jal      = is_jal;
    dec.jr       = is_jr;
  end
  // The load in ID/EX writes its rt; any consumer of that register must wait one cycle.
  assign haz = bus.ds_i_valid & valid_q & out_q.memtoreg & (out_q.rt != '0) &
               ((uses_rs & (dec.rs == out_q.rt)) | (uses_rt & (dec.rt == out_q.rt)));
  assign ld = ~valid_q | bus.ds_i_ready;
  assign bus.ds_o_ready = ld & ~haz & ~bus.ds_i_flush;
  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;
    if (bus.ds_i_flush) valid_d = 1'b0;
    else if (ld & haz) begin
      valid_d = 1'b0;
      out_d   = '0;
    end else if (ld & bus.ds_i_valid) begin
      valid_d   = legal;
      illegal_d = ~legal;
      out_d     = legal ? dec : out_q;
    end else if (ld) valid_d = 1'b0;
  end
  always_ff @(posedge ds_i_clk or negedge ds_i_rst)
    if (!ds_i_rst) begin
      out_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
`ifdef DECODE_STAGE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_d, cnt_q;
  assign cnt_d = (~bus.ds_i_flush & ld & haz & ~&cnt_q) ? cnt_q + STALL_CNT_W'(1) : cnt_q;
  always_ff @(posedge ds_i_clk or negedge ds_i_rst)
    if (!ds_i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.ds_o_stall_cnt = cnt_q;
`else
  assign bus.ds_o_stall_cnt = '0;
`endif
  assign bus.ds_o_valid    = valid_q;
  assign bus.ds_o_illegal  = illegal_q;
  assign bus.ds_o_opcode   = out_q.opcode;
  assign bus.ds_o_funct    = out_q.funct;
  assign bus.ds_o_addr_rs  = out_q.rs;
  assign bus.ds_o_addr_rt  = out_q.rt;
  assign bus.ds_o_addr_rd  = out_q.rd;
  assign bus.ds_o_imm      = out_q.imm;
  assign bus.ds_o_target   = out_q.target;
  assign bus.ds_o_link     = out_q.link;
  assign bus.ds_o_alu_src  = out_q.alu_src;
  assign bus.ds_o_reg_wr   = out_q.reg_wr;
  assign bus.ds_o_memwrite = out_q.memwrite;
  assign bus.ds_o_memtoreg = out_q.memtoreg;
  assign bus.ds_o_branch   = out_q.branch;
  assign bus.ds_o_jal      = out_q.jal;
  assign bus.ds_o_jr       = out_q.jr;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a behavioural model.
module tb_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  decode_stage_if bus ();
  decode_stage dut (.ds_i_clk(clk), .ds_i_rst(rst_n), .bus(bus));

  typedef struct packed {
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, target, link;
    logic        alu_src, reg_wr, memwrite, memtoreg, branch, jal, jr;
  } dec_t;

`ifdef DECODE_STAGE_STALL_CNT_EN
  localparam int LU_CNT = 1;
`else
  localparam int LU_CNT = 0;
`endif

  int cmp = 0, err = 0;
  logic m_v = 1'b0, m_ill = 1'b0, r_got, r_exp;
  dec_t m_o = '0;
  int m_cnt = 0;

  function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, output logic legal);
    dec_t d;
    logic [31:0] se;
    se = {{16{ins[15]}}, ins[15:0]};
    d = '0;
    d.opcode = ins[31:26];
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    d.link = pc + 32'd4;
    legal = 1'b1;
    case (ins[31:26])
      6'h00: begin
        d.funct = ins[5:0];
        d.rd = ins[15:11];
        if (ins[5:0] == 6'h08) begin d.rs = 5'd31; d.jr = 1'b1; end
        else d.reg_wr = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b: begin d.alu_src = 1; d.reg_wr = 1; d.imm = se; end
      6'h0c, 6'h0d: begin d.alu_src = 1; d.reg_wr = 1; d.imm = {16'h0, ins[15:0]}; end
      6'h23: begin d.alu_src = 1; d.reg_wr = 1; d.memtoreg = 1; d.imm = se; end
      6'h2b: begin d.alu_src = 1; d.memwrite = 1; d.imm = se; end
      6'h04, 6'h05: begin d.branch = 1; d.imm = se; d.target = pc + 32'd4 + se * 32'd4; end
      6'h03: begin d.rd = 5'd31; d.reg_wr = 1; d.jal = 1; d.target = {d.link[31:28], ins[25:0], 2'b00}; end
      default: legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic reads(input logic [31:0] ins, input logic [4:0] r);
    logic [5:0] op;
    logic [4:0] rs;
    logic rs_use, rt_use;
    op = ins[31:26];
    rs_use = op inside {6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h23, 6'h2b};
    rt_use = op inside {6'h00, 6'h04, 6'h05, 6'h2b};
    rs = (op == 6'h00 && ins[5:0] == 6'h08) ? 5'd31 : ins[25:21];
    return (rs_use && rs == r) || (rt_use && ins[20:16] == r);
  endfunction

  function automatic dec_t got();
    return {bus.ds_o_opcode, bus.ds_o_funct, bus.ds_o_addr_rs, bus.ds_o_addr_rt, bus.ds_o_addr_rd,
            bus.ds_o_imm, bus.ds_o_target, bus.ds_o_link, bus.ds_o_alu_src, bus.ds_o_reg_wr,
            bus.ds_o_memwrite, bus.ds_o_memtoreg, bus.ds_o_branch, bus.ds_o_jal, bus.ds_o_jr};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    int k;
    k = $urandom_range(0, 14);
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    case (k)
      0, 1: op = 6'h00;
      2, 3: op = 6'h23;
      4: op = 6'h2b;
      5: op = 6'h04;
      6: op = 6'h05;
      7: op = 6'h08;
      8: op = 6'h09;
      9: op = 6'h0a;
      10: op = 6'h0b;
      11: op = 6'h0c;
      12: op = 6'h0d;
      13: op = 6'h03;
      default: op = 6'h3f;
    endcase
    if (op == 6'h00) begin
      k = $urandom_range(0, 2);
      imm = {rd, 5'd0, (k == 0) ? 6'h20 : (k == 1) ? 6'h22 : 6'h08};
    end
    return (op == 6'h03) ? {op, 26'($urandom)} : {op, rs, rt, imm};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl, input logic rdy);
    dec_t d;
    logic lg, ld, haz;
    bus.ds_i_valid = v;
    bus.ds_i_instr = ins;
    bus.ds_i_pc = pc;
    bus.ds_i_flush = fl;
    bus.ds_i_ready = rdy;
    #1 r_got = bus.ds_o_ready;
    d = ref_dec(ins, pc, lg);
    ld = !m_v || rdy;
    haz = v && m_v && m_o.memtoreg && m_o.rt != 5'd0 && reads(ins, m_o.rt);
    r_exp = ld && !haz && !fl;
    m_ill = 1'b0;
    if (fl) m_v = 1'b0;
    else if (ld && haz) begin
      m_v = 1'b0;
      m_o = '0;
`ifdef DECODE_STAGE_STALL_CNT_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end else if (ld && v) begin
      if (lg) begin m_o = d; m_v = 1'b1; end
      else begin m_v = 1'b0; m_ill = 1'b1; end
    end else if (ld) m_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ds_i_valid = 0;
    bus.ds_i_flush = 0;
    bus.ds_i_ready = 1;
    rst_n = 1'b0;
    m_v = 0; m_ill = 0; m_o = '0; m_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cmp++; if (got() !== '0 || bus.ds_o_valid !== 1'b0 || bus.ds_o_illegal !== 1'b0) begin err++; $display("FAIL reset_state: fields=%h valid=%b illegal=%b, want all 0", got(), bus.ds_o_valid, bus.ds_o_illegal); end
    cmp++; if (bus.ds_o_stall_cnt !== 16'd0) begin err++; $display("FAIL reset_cnt: got %0d want 0", bus.ds_o_stall_cnt); end
    step(1, 32'h20050007, 32'h40, 0, 1);
    cmp++; if (bus.ds_o_valid !== 1'b1) begin err++; $display("FAIL pre_reset_valid: got %b want 1", bus.ds_o_valid); end
    #2 rst_n = 1'b0;
    #1;
    cmp++; if (bus.ds_o_valid !== 1'b0 || got() !== '0) begin err++; $display("FAIL async_reset: valid=%b fields=%h, want 0", bus.ds_o_valid, got()); end
    m_v = 0; m_ill = 0; m_o = '0; m_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 32'h2001FFFC, 32'h0, 0, 1);
    cmp++; if (bus.ds_o_valid !== 1'b1 || bus.ds_o_imm !== 32'hFFFFFFFC || bus.ds_o_alu_src !== 1'b1 || bus.ds_o_reg_wr !== 1'b1)
      begin err++; $display("FAIL addi_first: valid=%b imm=%h alu_src=%b reg_wr=%b, want 1 fffffffc 1 1", bus.ds_o_valid, bus.ds_o_imm, bus.ds_o_alu_src, bus.ds_o_reg_wr); end
  endtask

  task automatic test_imm_branch();
    step(1, 32'h30228000, 32'h4, 0, 1);
    cmp++; if (bus.ds_o_imm !== 32'h00008000 || bus.ds_o_addr_rd !== 5'd0) begin err++; $display("FAIL andi_zext: imm=%h rd=%0d want 00008000 0", bus.ds_o_imm, bus.ds_o_addr_rd); end
    step(1, 32'h1000FFFF, 32'h100, 0, 1);
    cmp++; if (bus.ds_o_target !== 32'h100 || bus.ds_o_branch !== 1'b1 || bus.ds_o_link !== 32'h104) begin err++; $display("FAIL beq_target: target=%h branch=%b link=%h want 100 1 104", bus.ds_o_target, bus.ds_o_branch, bus.ds_o_link); end
  endtask

  task automatic test_load_use();
    do_reset();
    step(1, 32'h8C230000, 32'h0, 0, 1);
    cmp++; if (bus.ds_o_valid !== 1'b1 || bus.ds_o_memtoreg !== 1'b1) begin err++; $display("FAIL lw_issue: valid=%b memtoreg=%b want 1 1", bus.ds_o_valid, bus.ds_o_memtoreg); end
    step(1, 32'h00652020, 32'h4, 0, 1);
    cmp++; if (r_got !== 1'b0 || bus.ds_o_valid !== 1'b0) begin err++; $display("FAIL bubble: ready=%b valid=%b want 0 0", r_got, bus.ds_o_valid); end
    step(1, 32'h00652020, 32'h4, 0, 1);
    cmp++; if (r_got !== 1'b1 || bus.ds_o_valid !== 1'b1 || bus.ds_o_addr_rd !== 5'd4 || bus.ds_o_funct !== 6'h20) begin err++; $display("FAIL add_after_bubble: ready=%b valid=%b rd=%0d funct=%h want 1 1 4 20", r_got, bus.ds_o_valid, bus.ds_o_addr_rd, bus.ds_o_funct); end
    cmp++; if (bus.ds_o_stall_cnt !== 16'(LU_CNT)) begin err++; $display("FAIL stall_cnt: got %0d want %0d", bus.ds_o_stall_cnt, LU_CNT); end
    step(1, 32'h8C200000, 32'h8, 0, 1);
    step(1, 32'h00052020, 32'hC, 0, 1);
    cmp++; if (r_got !== 1'b1 || bus.ds_o_valid !== 1'b1 || bus.ds_o_addr_rd !== 5'd4) begin err++; $display("FAIL lw_r0_no_bubble: ready=%b valid=%b rd=%0d want 1 1 4", r_got, bus.ds_o_valid, bus.ds_o_addr_rd); end
    cmp++; if (bus.ds_o_stall_cnt !== 16'(LU_CNT)) begin err++; $display("FAIL stall_cnt_r0: got %0d want %0d", bus.ds_o_stall_cnt, LU_CNT); end
  endtask

  task automatic test_backpressure();
    dec_t a, b;
    logic lg;
    a = ref_dec(32'h34061234, 32'h200, lg);
    b = ref_dec(32'h24070005, 32'h204, lg);
    step(1, 32'h34061234, 32'h200, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h24070005, 32'h204, 0, 0);
      cmp++; if (r_got !== 1'b0 || bus.ds_o_valid !== 1'b1 || got() !== a) begin err++; $display("FAIL hold_%0d: ready=%b valid=%b fields=%h want 0 1 %h", i, r_got, bus.ds_o_valid, got(), a); end
    end
    step(1, 32'h24070005, 32'h204, 0, 1);
    cmp++; if (r_got !== 1'b1 || bus.ds_o_valid !== 1'b1 || got() !== b) begin err++; $display("FAIL resume: ready=%b valid=%b fields=%h want 1 1 %h", r_got, bus.ds_o_valid, got(), b); end
    step(0, 32'h0, 32'h0, 0, 1);
    cmp++; if (bus.ds_o_valid !== 1'b0) begin err++; $display("FAIL drain: valid=%b want 0", bus.ds_o_valid); end
  endtask

  task automatic test_flush_hazard();
    int c0;
    step(1, 32'h8C230000, 32'h0, 0, 1);
    c0 = m_cnt;
    step(1, 32'h00652020, 32'h4, 1, 1);
    cmp++; if (r_got !== 1'b0 || bus.ds_o_valid !== 1'b0 || bus.ds_o_stall_cnt !== 16'(c0)) begin err++; $display("FAIL flush_haz: ready=%b valid=%b cnt=%0d want 0 0 %0d", r_got, bus.ds_o_valid, bus.ds_o_stall_cnt, c0); end
    step(1, 32'h00652020, 32'h4, 0, 1);
    cmp++; if (r_got !== 1'b1 || bus.ds_o_valid !== 1'b1) begin err++; $display("FAIL post_flush: ready=%b valid=%b want 1 1", r_got, bus.ds_o_valid); end
  endtask

  task automatic test_illegal_jal();
    step(1, 32'hFC000000, 32'h300, 0, 1);
    cmp++; if (bus.ds_o_illegal !== 1'b1 || bus.ds_o_valid !== 1'b0) begin err++; $display("FAIL illegal: illegal=%b valid=%b want 1 0", bus.ds_o_illegal, bus.ds_o_valid); end
    step(1, 32'h0C000040, 32'h10000000, 0, 1);
    cmp++; if (bus.ds_o_illegal !== 1'b0 || bus.ds_o_valid !== 1'b1) begin err++; $display("FAIL illegal_pulse: illegal=%b valid=%b want 0 1", bus.ds_o_illegal, bus.ds_o_valid); end
    cmp++; if (bus.ds_o_target !== 32'h10000100 || bus.ds_o_link !== 32'h10000004 || bus.ds_o_addr_rd !== 5'd31 || bus.ds_o_jal !== 1'b1)
      begin err++; $display("FAIL jal: target=%h link=%h rd=%0d jal=%b want 10000100 10000004 31 1", bus.ds_o_target, bus.ds_o_link, bus.ds_o_addr_rd, bus.ds_o_jal); end
  endtask

  task automatic test_random();
    logic v, fl, rdy;
    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 15) == 0;
      rdy = $urandom_range(0, 3) != 0;
      step(v, rand_instr(), $urandom & 32'hFFFFFFFC, fl, rdy);
      cmp++; if (r_got !== r_exp) begin err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, r_got, r_exp); end
      cmp++; if (bus.ds_o_valid !== m_v || bus.ds_o_illegal !== m_ill) begin err++; $display("FAIL rnd_valid[%0d]: valid=%b illegal=%b want %b %b", i, bus.ds_o_valid, bus.ds_o_illegal, m_v, m_ill); end
      cmp++; if (got() !== m_o) begin err++; $display("FAIL rnd_fields[%0d]: got %h want %h", i, got(), m_o); end
      cmp++; if (bus.ds_o_stall_cnt !== 16'(m_cnt)) begin err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, bus.ds_o_stall_cnt, m_cnt); end
    end
  endtask

  initial begin
    bus.ds_i_valid = 0;
    bus.ds_i_instr = 0;
    bus.ds_i_pc = 0;
    bus.ds_i_flush = 0;
    bus.ds_i_ready = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_imm_branch();
    test_load_use();
    test_backpressure();
    test_flush_hazard();
    test_illegal_jal();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
